// File: rtl/uart_rx_fifo_if.sv
// CPU register-window and UART receive-side signals of uart_rx_fifo (bData stays a plain inout port).
interface uart_rx_fifo_if;
  logic [1:0] iAddr;
  logic       iWrite;
  logic       iEnable;
  logic [7:0] iRxData;
  logic       iRxStrobe;
  logic       oInt;
  logic       oFull;

  modport master (
    output iAddr, iWrite, iEnable, iRxData, iRxStrobe,
    input  oInt, oFull
  );

  modport slave (
    input  iAddr, iWrite, iEnable, iRxData, iRxStrobe,
    output oInt, oFull
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind the UART with a 4-word CPU register window, threshold/overrun interrupt.
// Define UART_RX_FIFO_TIMEOUT_EN to build the idle receive-timeout flag; reads are combinational, oInt/oFull lag one edge.
module uart_rx_fifo #(
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic          iClk,
  input  logic          iRst,
  inout  wire  [31:0]   bData,
  uart_rx_fifo_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   level_q, level_d, thresh_q, thresh_d, wthr;
  logic              ovr_q, ovr_d, int_en_q, int_en_d, rd1_q, rd1_d;
  logic              int_q, int_d, full_q, full_d, to_q;
  logic              rd_acc, wr_acc, wr0, wr2, empty, full, flush, pop, push, ovr_set, thresh_hit;
  logic [31:0]       rdata;
  wire               unused_wdat = ^bData;

  assign rd_acc     = bus.iEnable & ~bus.iWrite;
  assign wr_acc     = bus.iEnable & bus.iWrite;
  assign wr0        = wr_acc & (bus.iAddr == 2'd0);
  assign wr2        = wr_acc & (bus.iAddr == 2'd2);
  assign empty      = (level_q == '0);
  assign full       = (level_q == DEPTH_L);
  assign flush      = wr0 & bData[7];
  assign thresh_hit = (level_q >= thresh_q);

  // A held addr1 read is one access: only its first cycle may pop.
  assign rd1_d   = rd_acc & (bus.iAddr == 2'd1);
  assign pop     = rd1_d & ~rd1_q & ~empty & ~flush;
  assign push    = bus.iRxStrobe & ~flush & (~full | pop);
  assign ovr_set = bus.iRxStrobe & ~flush & full & ~pop;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (push && !pop)      level_d = level_q + (ADDR_W+1)'(1);
      else if (pop && !push) level_d = level_q - (ADDR_W+1)'(1);
    end
  end

  always_comb begin
    wthr     = bData[ADDR_W:0];
    ovr_d    = ovr_set | (ovr_q & ~(wr0 & bData[2]));
    int_en_d = wr0 ? bData[6] : int_en_q;
    thresh_d = thresh_q;
    if (wr2) begin
      if (wthr == '0)          thresh_d = (ADDR_W+1)'(1);
      else if (wthr > DEPTH_L) thresh_d = DEPTH_L;
      else                     thresh_d = wthr;
    end
    int_d  = int_en_q & (thresh_hit | ovr_q | to_q);
    full_d = (level_d == DEPTH_L);
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      thresh_q <= (ADDR_W+1)'(1);
      ovr_q    <= 1'b0;
      int_en_q <= 1'b0;
      rd1_q    <= 1'b0;
      int_q    <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      thresh_q <= thresh_d;
      ovr_q    <= ovr_d;
      int_en_q <= int_en_d;
      rd1_q    <= rd1_d;
      int_q    <= int_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge iClk) begin
    if (push) mem_q[wr_ptr_q] <= bus.iRxData;
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] TO_L = CNT_W'(TIMEOUT);
  logic [CNT_W-1:0] idle_q, idle_d;
  logic             to_d;

  always_comb begin
    idle_d = idle_q;
    if (push | pop | flush | empty) idle_d = '0;
    else if (idle_q != TO_L)        idle_d = idle_q + CNT_W'(1);
    to_d = ((idle_q == TO_L) & ~empty & ~flush) | (to_q & ~(wr0 & bData[4]));
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      idle_q <= '0;
      to_q   <= 1'b0;
    end else begin
      idle_q <= idle_d;
      to_q   <= to_d;
    end
  end
`else
  wire unused_timeout = |TIMEOUT;
  assign to_q = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    case (bus.iAddr)
      2'd0: begin
        rdata[0]              = empty;
        rdata[1]              = full;
        rdata[2]              = ovr_q;
        rdata[3]              = thresh_hit;
        rdata[4]              = to_q;
        rdata[6]              = int_en_q;
        rdata[8 +: ADDR_W+1]  = level_q;
      end
      2'd1: if (!empty) rdata[8:0] = {1'b1, mem_q[rd_ptr_q]};
      2'd2: rdata[ADDR_W:0] = thresh_q;
      default: rdata[ADDR_W:0] = level_q;
    endcase
  end

  assign bData   = rd_acc ? rdata : 32'bz;
  assign bus.oInt  = int_q;
  assign bus.oFull = full_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: register-vector table, directed corner sequences, random traffic against a queue model.
module tb_uart_rx_fifo;
  localparam int TO_T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        drv_en;
  logic [31:0] drv_val;
  wire  [31:0] bData;
  int          n_cmp, n_bad;

  uart_rx_fifo_if u_if ();
  assign bData = drv_en ? drv_val : 32'bz;

  uart_rx_fifo #(.ADDR_W(4), .TIMEOUT(TO_T)) dut (
    .iClk (clk),
    .iRst (rst),
    .bData(bData),
    .bus  (u_if)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [7:0] mq[$];
  logic       m_ovr, m_ien, m_to, m_prev;
  int         m_thr, m_idle;

  typedef struct {
    logic        en, wr;
    logic [1:0]  addr;
    logic [31:0] wdat;
    logic        stb;
    logic [7:0]  rxd;
    logic        chk;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic en, logic wr, logic [1:0] a, logic [31:0] wd,
                              logic stb, logic [7:0] rxd, logic chk, logic [31:0] exp);
    vec_t v;
    v.en = en; v.wr = wr; v.addr = a; v.wdat = wd; v.stb = stb; v.rxd = rxd; v.chk = chk; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovr = 0; m_ien = 0; m_to = 0; m_prev = 0; m_thr = 1; m_idle = 0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    logic [31:0] r;
    int s;
    s = mq.size();
    r = '0;
    case (a)
      2'd0: begin
        r[0] = (s == 0); r[1] = (s == 16); r[2] = m_ovr; r[3] = (s >= m_thr);
        r[4] = m_to; r[6] = m_ien; r[15:8] = 8'(s);
      end
      2'd1: if (s > 0) r = {23'b0, 1'b1, mq[0]};
      2'd2: r = 32'(m_thr);
      default: r = 32'(s);
    endcase
    return r;
  endfunction

  // One bus cycle: drive, sample combinational read, update model, clock, check registered outputs.
  task automatic cyc(input logic en, input logic wr, input logic [1:0] a, input logic [31:0] wd,
                     input logic stb, input logic [7:0] rxd, output logic [31:0] rd);
    logic flush, rd1, pop, push_ok, ovr_set, to_set, exp_int;
    logic [4:0] wthr;
    int s0;
    u_if.iEnable = en; u_if.iWrite = wr; u_if.iAddr = a;
    u_if.iRxStrobe = stb; u_if.iRxData = rxd;
    drv_en = en & wr; drv_val = wd;
    #1;
    rd = bData;
    if (en && !wr) chk("rd_data", rd, exp_rd(a));
    s0 = mq.size();
    exp_int = m_ien && ((s0 >= m_thr) || m_ovr || m_to);
    flush = en && wr && a == 2'd0 && wd[7];
    rd1 = en && !wr && a == 2'd1;
    pop = rd1 && !m_prev && s0 > 0 && !flush;
    m_prev = rd1;
    push_ok = 0; ovr_set = 0; to_set = 0;
`ifdef UART_RX_FIFO_TIMEOUT_EN
    to_set = (m_idle == TO_T) && s0 > 0 && !flush;
`endif
    if (flush) mq.delete();
    else begin
      push_ok = stb && (s0 < 16 || pop);
      ovr_set = stb && !push_ok;
      if (pop) void'(mq.pop_front());
      if (push_ok) mq.push_back(rxd);
    end
    if (push_ok || pop || flush || s0 == 0) m_idle = 0;
    else if (m_idle < TO_T) m_idle++;
    if (ovr_set) m_ovr = 1;
    else if (en && wr && a == 2'd0 && wd[2]) m_ovr = 0;
    if (to_set) m_to = 1;
    else if (en && wr && a == 2'd0 && wd[4]) m_to = 0;
    if (en && wr && a == 2'd0) m_ien = wd[6];
    if (en && wr && a == 2'd2) begin
      wthr = wd[4:0];
      m_thr = (wthr == 0) ? 1 : (wthr > 16) ? 16 : int'(wthr);
    end
    @(posedge clk);
    #1;
    chk("oInt", u_if.oInt, exp_int);
    chk("oFull", u_if.oFull, mq.size() == 16);
  endtask

  task automatic idle(input int n);
    logic [31:0] d;
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, d);
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  b;
    int          r;
    n_cmp = 0; n_bad = 0;
    model_reset();
    rst = 1; drv_en = 0; drv_val = 0;
    u_if.iEnable = 0; u_if.iWrite = 0; u_if.iAddr = 0; u_if.iRxStrobe = 0; u_if.iRxData = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_oInt", u_if.oInt, 0);
    chk("rst_oFull", u_if.oFull, 0);
    drv_en = 1; drv_val = 32'hA5A5_5A5A;
    #1 chk("bus_hiz", bData, 32'hA5A5_5A5A);
    drv_en = 0;

    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 32'h0000_0001));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'h41, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'h42, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'h43, 0, 0));
    tbl.push_back(mk(1, 0, 3, 0, 0, 0, 1, 32'h3));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1, 32'h141));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1, 32'h142));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1, 32'h143));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1, 32'h0));
    tbl.push_back(mk(1, 0, 3, 0, 0, 0, 1, 32'h0));
    tbl.push_back(mk(1, 1, 2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 2, 0, 0, 0, 1, 32'h1));
    tbl.push_back(mk(1, 1, 2, 31, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 2, 0, 0, 0, 1, 32'h10));
    tbl.push_back(mk(1, 1, 2, 4, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 2, 0, 0, 0, 1, 32'h4));
    foreach (tbl[i]) begin
      cyc(tbl[i].en, tbl[i].wr, tbl[i].addr, tbl[i].wdat, tbl[i].stb, tbl[i].rxd, rd);
      if (tbl[i].chk) chk($sformatf("vec%0d", i), rd, tbl[i].exp);
    end

    // Threshold interrupt rise and fall.
    cyc(1, 1, 0, 32'h40, 0, 0, rd);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 8'(8'h60 + i), rd);
    chk("int_early", u_if.oInt, 0);
    idle(1);
    chk("int_rise", u_if.oInt, 1);
    cyc(1, 0, 1, 0, 0, 0, rd);
    chk("int_pop_rd", rd, 32'h160);
    idle(1);
    chk("int_fall", u_if.oInt, 0);
    cyc(1, 1, 0, 32'h80, 0, 0, rd);

    // Overrun on the 17th push.
    for (int i = 0; i < 17; i++) begin
      cyc(0, 0, 0, 0, 1, 8'(i), rd);
      if (i == 15) chk("full_16", u_if.oFull, 1);
    end
    cyc(1, 0, 0, 0, 0, 0, rd);
    chk("ovr_set", rd[2], 1);
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 1, 0, 0, 0, rd);
      chk("ovf_rd", rd, 32'h100 | i);
      idle(1);
    end
    cyc(1, 1, 0, 32'h04, 0, 0, rd);
    cyc(1, 0, 0, 0, 0, 0, rd);
    chk("ovr_clr", rd[2], 0);

    // Full FIFO: push and pop in the same cycle.
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, 1, 8'(8'h20 + i), rd);
    cyc(1, 0, 1, 0, 1, 8'hAA, rd);
    chk("fullpp_rd", rd, 32'h120);
    cyc(1, 0, 3, 0, 0, 0, rd);
    chk("fullpp_lvl", rd, 32'h10);
    cyc(1, 0, 0, 0, 0, 0, rd);
    chk("fullpp_ovr", rd[2], 0);
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 1, 0, 0, 0, rd);
      chk("drain_rd", rd, (i < 15) ? (32'h121 + i) : 32'h1AA);
      idle(1);
    end
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom);
      cyc(0, 0, 0, 0, 1, b, rd);
      cyc(1, 0, 1, 0, 0, 0, rd);
      chk("wrap_rd", rd, {23'b0, 1'b1, b});
    end

    // Flush wins over a coincident push.
    cyc(0, 0, 0, 0, 1, 8'h11, rd);
    cyc(0, 0, 0, 0, 1, 8'h22, rd);
    cyc(1, 1, 0, 32'h80, 1, 8'h33, rd);
    cyc(1, 0, 3, 0, 0, 0, rd);
    chk("flush_lvl", rd, 32'h0);
    cyc(1, 0, 0, 0, 0, 0, rd);
    chk("flush_stat", rd, 32'h1);

    // Idle with one byte held: timeout only in the feature build.
    cyc(0, 0, 0, 0, 1, 8'h77, rd);
    idle(TO_T + 4);
    cyc(1, 0, 0, 0, 0, 0, rd);
`ifdef UART_RX_FIFO_TIMEOUT_EN
    chk("timeout_bit", rd[4], 1);
`else
    chk("timeout_bit", rd[4], 0);
`endif
    cyc(1, 1, 0, 32'h40, 0, 0, rd);
    idle(1);
`ifdef UART_RX_FIFO_TIMEOUT_EN
    chk("timeout_int", u_if.oInt, 1);
`else
    chk("timeout_int", u_if.oInt, 0);
`endif
    cyc(1, 1, 0, 32'h94, 0, 0, rd);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 35)      cyc(1, 0, 1, 0, $urandom_range(0, 99) < 45, 8'($urandom), rd);
      else if (r < 45) cyc(1, 0, 2'($urandom_range(0, 3)), 0, $urandom_range(0, 99) < 45, 8'($urandom), rd);
      else if (r < 50) cyc(1, 1, 0, ($urandom & 32'h54) | (($urandom_range(0, 7) == 0) ? 32'h80 : 32'h0),
                           $urandom_range(0, 99) < 45, 8'($urandom), rd);
      else if (r < 53) cyc(1, 1, 2, $urandom_range(0, 31), $urandom_range(0, 99) < 45, 8'($urandom), rd);
      else             cyc(0, 0, 0, 0, $urandom_range(0, 99) < 45, 8'($urandom), rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
